// File: rtl/nn_job_arbiter.sv
// Round-robin arbiter sharing one neural-network engine among NREQ requesters.
// Each job steps through ISSUE, ARM and WAIT, then DELIVER; a watchdog aborts a hung engine.
module nn_job_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int N       = 16,
    parameter  int TIMEOUT = 1023,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [NREQ-1:0] done,
    output logic [N-1:0]    result,
    output logic            err,
    output logic            timeout_seen,
    output logic            busy,
    output logic [IW-1:0]   grant_id,
    output logic            nn_start,
    input  logic            nn_ready,
    input  logic [N-1:0]    nn_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_DELIVER
    } state_t;

    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    result_q, result_d;
    logic            err_q, err_d;
    logic            tseen_q, tseen_d;
    logic [IW-1:0]   rr_win;
    logic [NREQ-1:0] grant_mask;
    int              rr_idx;

    // Scan from lowest to highest priority so the last hit (closest after grant_id) wins.
    always_comb begin
        rr_win = grant_id_q;
        rr_idx = 0;
        for (int i = NREQ; i >= 1; i--) begin
            rr_idx = (int'(grant_id_q) + i) % NREQ;
            if (req[rr_idx]) begin
                rr_win = IW'(rr_idx);
            end
        end
    end

    assign grant_mask = NREQ'(1) << grant_id_q;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        err_d      = 1'b0;
        tseen_d    = tseen_q;
        nn_start   = 1'b0;
        ack        = '0;
        done       = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_id_d = rr_win;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                nn_start = 1'b1;
                ack      = grant_mask;
                cnt_d    = '0;
                state_d  = S_ARM;
            end
            S_ARM: begin
                // A ready level left over from the previous job is dropped here.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (nn_ready) begin
                    result_d = nn_out;
                    state_d  = S_DELIVER;
                end else begin
                    if (cnt_q != TO_C) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == TO_C) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        tseen_d  = 1'b1;
                        state_d  = S_DELIVER;
                    end
                end
            end
            S_DELIVER: begin
                done    = grant_mask;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            grant_id_q <= IW'(NREQ - 1);
            cnt_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            tseen_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            err_q      <= err_d;
            tseen_q    <= tseen_d;
        end
    end

    // err_q is only ever set on entry to DELIVER, so it is high exactly in the done cycle.
    assign err          = err_q;
    assign result       = result_q;
    assign timeout_seen = tseen_q;
    assign busy         = (state_q != S_IDLE);
    assign grant_id     = grant_id_q;

endmodule
